// File: rtl/mips_cpu_pkg.sv
// Shared types and default vectors for the MIPS core's program-counter logic.
package mips_cpu_pkg;

    // Next-PC selection presented by decode for the instruction at pc_out.
    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_JR     = 2'd3
    } pc_ctrl_t;

    // Sequencer run state; HALTED is left only through reset.
    typedef enum logic {
        PC_RUN    = 1'b0,
        PC_HALTED = 1'b1
    } pc_state_t;

    // Default boot, exception and halt addresses (kseg1 boot ROM region).
    localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'hBFC0_0380;
    localparam logic [31:0] DEF_HALT_ADDR    = 32'h0000_0000;

endpackage

// File: rtl/mips_cpu_pc_target.sv
// Combinational redirect-target mux: branch, jump and jump-register targets
// for the instruction currently at pc_in, plus the pc+4 link base.
module mips_cpu_pc_target
    import mips_cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [31:0]       instr,
    input  logic [31:0]       reg_readdata,
    input  pc_ctrl_t          pc_ctrl,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] branch_offset;
    logic [ADDR_W-1:0] jump_target;

    // Opcode bits are decoded elsewhere; only imm16 / instr_index matter here.
    logic unused_opcode;
    assign unused_opcode = ^instr[31:26];

    assign pc_plus4      = pc_in + ADDR_W'(4);
    assign branch_offset = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
    // The region bits come from the delay-slot address, not the jump itself.
    assign jump_target   = {pc_plus4[ADDR_W-1:ADDR_W-4], instr[25:0], 2'b00};

    // Select the redirect target; SEQ yields pc+4 so the output is never stale.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so no
        // path leaves it unassigned and a latch can never be inferred.
        target = pc_plus4;
        unique case (pc_ctrl)
            PC_SEQ:    target = pc_plus4;
            PC_BRANCH: target = pc_plus4 + branch_offset;
            PC_JUMP:   target = jump_target;
            PC_JR:     target = reg_readdata[ADDR_W-1:0];
            default:   target = pc_plus4;
        endcase
    end

endmodule

// File: rtl/mips_cpu_pc_seq.sv
// Program-counter sequencer: sequential / branch / J / JR flow with optional
// branch delay slot, stall, exception redirect with EPC/BD capture, and halt.
module mips_cpu_pc_seq
    import mips_cpu_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = DEF_EXC_VECTOR,
    parameter logic [ADDR_W-1:0] HALT_ADDR    = DEF_HALT_ADDR,
    parameter bit                DELAY_SLOT   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  pc_ctrl_t          pc_ctrl,
    input  logic [31:0]       instr,
    input  logic [31:0]       reg_readdata,
    input  logic              exc_req,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              active,
    output logic              in_delay_slot,
    output logic [ADDR_W-1:0] epc,
    output logic              exc_bd
);

    pc_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;
    logic              pend_valid_q, pend_valid_d;
    logic              in_ds_q, in_ds_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              exc_bd_q, exc_bd_d;
    logic [ADDR_W-1:0] target;

    mips_cpu_pc_target #(
        .ADDR_W (ADDR_W)
    ) u_target (
        .pc_in        (pc_q),
        .instr        (instr),
        .reg_readdata (reg_readdata),
        .pc_ctrl      (pc_ctrl),
        .pc_plus4     (pc_plus4),
        .target       (target)
    );

    // Next-state logic in priority order: exception > stall > halt > redirect > sequential.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        pend_valid_d  = pend_valid_q;
        in_ds_d       = in_ds_q;
        epc_d         = epc_q;
        exc_bd_d      = exc_bd_q;

        if (state_q == PC_RUN) begin
            if (exc_req) begin
                // A faulting delay-slot instruction restarts at its branch.
                pc_d         = EXC_VECTOR;
                pend_valid_d = 1'b0;
                in_ds_d      = 1'b0;
                epc_d        = in_ds_q ? (pc_q - ADDR_W'(4)) : pc_q;
                exc_bd_d     = in_ds_q;
            end else if (!stall) begin
                if (pc_q == HALT_ADDR) begin
                    state_d = PC_HALTED;
                end else if (DELAY_SLOT) begin
                    if (pend_valid_q) begin
                        // Leaving the delay slot; any control in the slot is ignored.
                        pc_d         = pend_target_q;
                        pend_valid_d = 1'b0;
                        in_ds_d      = 1'b0;
                    end else if (pc_ctrl != PC_SEQ) begin
                        // Target (incl. JR's rs value) is captured now, at decode.
                        pend_target_d = target;
                        pend_valid_d  = 1'b1;
                        pc_d          = pc_plus4;
                        in_ds_d       = 1'b1;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end else begin
                    pc_d = (pc_ctrl != PC_SEQ) ? target : pc_plus4;
                end
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: flops are written only with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q       <= PC_RUN;
            pc_q          <= RESET_VECTOR;
            pend_target_q <= '0;
            pend_valid_q  <= 1'b0;
            in_ds_q       <= 1'b0;
            epc_q         <= '0;
            exc_bd_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            pend_valid_q  <= pend_valid_d;
            in_ds_q       <= in_ds_d;
            epc_q         <= epc_d;
            exc_bd_q      <= exc_bd_d;
        end
    end

    assign pc_out        = pc_q;
    assign active        = (state_q == PC_RUN);
    assign in_delay_slot = in_ds_q;
    assign epc           = epc_q;
    assign exc_bd        = exc_bd_q;

endmodule

// File: tb/tb_mips_cpu_pc_seq.sv
// Directed bench for mips_cpu_pc_seq: a delay-slot build and an immediate-redirect
// build share one set of inputs and are checked against hand-computed addresses.
module tb_mips_cpu_pc_seq;
    import mips_cpu_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    pc_ctrl_t    pc_ctrl;
    logic [31:0] instr;
    logic [31:0] reg_readdata;
    logic        exc_req;

    logic [31:0] pc_out,   pc_out0;
    logic [31:0] pc_plus4, pc_plus40;
    logic        active,   active0;
    logic        in_ds,    in_ds0;
    logic [31:0] epc,      epc0;
    logic        exc_bd,   exc_bd0;

    int n_cmp = 0;
    int n_err = 0;

    mips_cpu_pc_seq #(.DELAY_SLOT(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .pc_ctrl       (pc_ctrl),
        .instr         (instr),
        .reg_readdata  (reg_readdata),
        .exc_req       (exc_req),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .active        (active),
        .in_delay_slot (in_ds),
        .epc           (epc),
        .exc_bd        (exc_bd)
    );

    mips_cpu_pc_seq #(.DELAY_SLOT(1'b0)) dut_nods (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .pc_ctrl       (pc_ctrl),
        .instr         (instr),
        .reg_readdata  (reg_readdata),
        .exc_req       (exc_req),
        .pc_out        (pc_out0),
        .pc_plus4      (pc_plus40),
        .active        (active0),
        .in_delay_slot (in_ds0),
        .epc           (epc0),
        .exc_bd        (exc_bd0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled and inputs changed 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input pc_ctrl_t c, input logic [31:0] ins, input logic [31:0] rd);
        pc_ctrl      = c;
        instr        = ins;
        reg_readdata = rd;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        exc_req = 1'b0;
        drive(PC_SEQ, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Run n sequential instructions.
    task automatic seq_n(input int n);
        drive(PC_SEQ, 32'h0, 32'h0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        exc_req = 1'b0;
        drive(PC_SEQ, 32'h0, 32'h0);
        #2;

        // 1: reset state and sequential fetch
        do_reset();
        check("rst_pc",     pc_out,  32'hBFC0_0000);
        check("rst_active", {31'b0, active}, 32'd1);
        check("rst_ds",     {31'b0, in_ds},  32'd0);
        check("rst_epc",    epc,     32'h0);
        check("rst_bd",     {31'b0, exc_bd}, 32'd0);
        check("rst_plus4",  pc_plus4, 32'hBFC0_0004);
        seq_n(1); check("seq1", pc_out, 32'hBFC0_0004);
        seq_n(1); check("seq2", pc_out, 32'hBFC0_0008);
        seq_n(1); check("seq3", pc_out, 32'hBFC0_000C);
        check("seq3_nods", pc_out0, 32'hBFC0_000C);

        // 2: backward branch, target BFC00014 - 16 = BFC00004
        seq_n(1); check("br_at", pc_out, 32'hBFC0_0010);
        drive(PC_BRANCH, 32'h1000_FFFC, 32'h0);
        tick();
        check("br_slot",    pc_out, 32'hBFC0_0014);
        check("br_slot_ds", {31'b0, in_ds}, 32'd1);
        check("br_nods",    pc_out0, 32'hBFC0_0004);
        check("br_nods_ds", {31'b0, in_ds0}, 32'd0);
        seq_n(1);
        check("br_tgt",    pc_out, 32'hBFC0_0004);
        check("br_tgt_ds", {31'b0, in_ds}, 32'd0);

        // 3: jump from BFC00020, target {B, 0x100<<2} = B0000400
        do_reset();
        seq_n(8); check("j_at", pc_out, 32'hBFC0_0020);
        drive(PC_JUMP, 32'h0800_0100, 32'h0);
        tick();
        check("j_slot", pc_out,  32'hBFC0_0024);
        check("j_nods", pc_out0, 32'hB000_0400);
        seq_n(1);
        check("j_tgt",  pc_out,  32'hB000_0400);

        // 5: stall inside a delay slot, with control presented and ignored
        do_reset();
        seq_n(4);
        drive(PC_BRANCH, 32'h0000_FFFC, 32'h0);
        tick();
        check("st_slot", pc_out, 32'hBFC0_0014);
        stall = 1'b1;
        drive(PC_JUMP, 32'h0800_0100, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_hold_pc", pc_out, 32'hBFC0_0014);
            check("st_hold_ds", {31'b0, in_ds}, 32'd1);
        end
        stall = 1'b0;
        // JR in the delay slot must not override the pending branch target.
        drive(PC_JR, 32'h0, 32'h1234_5678);
        tick();
        check("st_resume",    pc_out, 32'hBFC0_0004);
        check("st_resume_ds", {31'b0, in_ds}, 32'd0);
        seq_n(1);
        check("st_after", pc_out, 32'hBFC0_0008);

        // 6: exception in the delay slot at BFC00014
        do_reset();
        seq_n(4);
        drive(PC_BRANCH, 32'h0000_FFFC, 32'h0);
        tick();
        check("ex_slot", pc_out, 32'hBFC0_0014);
        drive(PC_SEQ, 32'h0, 32'h0);
        exc_req = 1'b1;
        stall = 1'b1;
        tick();
        exc_req = 1'b0;
        stall = 1'b0;
        check("ex_pc",   pc_out, 32'hBFC0_0380);
        check("ex_epc",  epc,    32'hBFC0_0010);
        check("ex_bd",   {31'b0, exc_bd}, 32'd1);
        check("ex_ds",   {31'b0, in_ds},  32'd0);
        check("ex_epc_nods", epc0, 32'hBFC0_0004);
        check("ex_bd_nods",  {31'b0, exc_bd0}, 32'd0);
        seq_n(1);
        check("ex_drop", pc_out, 32'hBFC0_0384);

        // 4: JR to 0 halts; target sampled on the decode edge
        do_reset();
        drive(PC_JR, 32'h0, 32'h0);
        tick();
        check("jr_slot", pc_out,  32'hBFC0_0004);
        check("jr_nods", pc_out0, 32'h0);
        drive(PC_SEQ, 32'h0, 32'hDEAD_BEEF);
        tick();
        check("jr_tgt",     pc_out, 32'h0);
        check("jr_active",  {31'b0, active},  32'd1);
        check("halt_nods",  {31'b0, active0}, 32'd0);
        tick();
        check("halt_active", {31'b0, active}, 32'd0);
        check("halt_pc",     pc_out, 32'h0);
        drive(PC_JUMP, 32'h0800_0100, 32'h4444_0000);
        exc_req = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        exc_req = 1'b0;
        check("halt_hold_pc", pc_out, 32'h0);
        check("halt_hold_ep", epc,    32'h0);
        check("halt_hold_bd", {31'b0, exc_bd}, 32'd0);

        // Reset mid delay slot discards the pending target.
        do_reset();
        check("rh_pc",     pc_out, 32'hBFC0_0000);
        check("rh_active", {31'b0, active}, 32'd1);
        drive(PC_BRANCH, 32'h0000_FFFC, 32'h0);
        tick();
        check("rd_slot", pc_out, 32'hBFC0_0004);
        rst = 1'b1;
        stall = 1'b1;
        tick();
        rst = 1'b0;
        stall = 1'b0;
        check("rd_pc", pc_out, 32'hBFC0_0000);
        check("rd_ds", {31'b0, in_ds}, 32'd0);
        seq_n(1); check("rd_seq1", pc_out, 32'hBFC0_0004);
        seq_n(1); check("rd_seq2", pc_out, 32'hBFC0_0008);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
